// File: rtl/iram2rwp.sv
// iram2rwp: single-clock true dual-port RAM with byte-enable writes,
// selectable read latency, deterministic same-address collision handling,
// sticky error flags and a clear sequencer that initialises the array.
module iram2rwp #(
  parameter int               ADDRBIT = 11,
  parameter int               DEPTH   = 1536,
  parameter int               WIDTH   = 32,
  parameter int               RDLAT   = 1,
  parameter string            COLMODE = "WRFIRST",
  parameter logic [WIDTH-1:0] CLRVAL  = '0,
  parameter int               CNTBIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 init,
  output logic                 busy,
  input  logic [ADDRBIT-1:0]   a0,
  input  logic                 we0,
  input  logic [WIDTH/8-1:0]   be0,
  input  logic [WIDTH-1:0]     di0,
  input  logic                 re0,
  output logic [WIDTH-1:0]     do0,
  output logic                 vld0,
  input  logic [ADDRBIT-1:0]   a1,
  input  logic                 we1,
  input  logic [WIDTH/8-1:0]   be1,
  input  logic [WIDTH-1:0]     di1,
  input  logic                 re1,
  output logic [WIDTH-1:0]     do1,
  output logic                 vld1,
  input  logic                 colclr,
  output logic                 colerr,
  output logic                 oorerr,
  output logic [CNTBIT-1:0]    colcnt
);

  localparam int                 NBYTE    = WIDTH / 8;
  localparam int                 IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRBIT:0]   DEPTH_W  = (ADDRBIT+1)'(DEPTH);
  localparam logic [ADDRBIT-1:0] LAST     = ADDRBIT'(DEPTH - 1);
  localparam bit                 RD_FIRST = (COLMODE == "RDFIRST");

  typedef enum logic {CLEAR, READY} state_t;

  state_t             state_q, state_d;
  logic [ADDRBIT-1:0] clraddr_q, clraddr_d;

  logic [WIDTH-1:0]   ram [0:DEPTH-1];

  logic [IDXW-1:0]    idx0, idx1, clridx;
  logic               inr0, inr1;
  logic               wr0_ok, wr1_ok, rd0, rd1;
  logic               col, oor;
  logic [WIDTH-1:0]   old0, old1, merged0, merged1, rdata0, rdata1;

  logic [WIDTH-1:0]   do0_q1, do1_q1;
  logic               vld0_q1, vld1_q1;

  assign busy   = (state_q == CLEAR);
  assign idx0   = a0[IDXW-1:0];
  assign idx1   = a1[IDXW-1:0];
  assign clridx = clraddr_q[IDXW-1:0];
  assign inr0   = ({1'b0, a0} < DEPTH_W);
  assign inr1   = ({1'b0, a1} < DEPTH_W);
  assign wr0_ok = !busy && we0 && inr0;
  assign wr1_ok = !busy && we1 && inr1;
  assign rd0    = !busy && re0;
  assign rd1    = !busy && re1;
  assign col    = !busy && (a0 == a1) && ((we0 && (we1 || re1)) || (we1 && re0));
  assign oor    = !busy && (((we0 || re0) && !inr0) || ((we1 || re1) && !inr1));
  assign old0   = ram[idx0];
  assign old1   = ram[idx1];
  assign rdata0 = !inr0 ? '0 : (RD_FIRST ? old0 : merged0);
  assign rdata1 = !inr1 ? '0 : (RD_FIRST ? old1 : merged1);

  // Sequencer state register; reset always restarts the clear from address 0.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= CLEAR;
      clraddr_q <= '0;
    end else begin
      state_q   <= state_d;
      clraddr_q <= clraddr_d;
    end
  end

  // Sequencer next state: walk the whole array once, then serve users until init.
  always_comb begin
    state_d   = state_q;
    clraddr_d = clraddr_q;
    case (state_q)
      CLEAR: begin
        clraddr_d = clraddr_q + ADDRBIT'(1);
        if (clraddr_q == LAST) begin
          state_d   = READY;
          clraddr_d = '0;
        end
      end
      READY: begin
        if (init) begin
          state_d   = CLEAR;
          clraddr_d = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Post-write word at each port's address: port 1 bytes first, port 0 on top.
  always_comb begin
    merged0 = old0;
    merged1 = old1;
    for (int k = 0; k < NBYTE; k++) begin
      if (wr1_ok && be1[k]) begin
        merged1[8*k +: 8] = di1[8*k +: 8];
        if (a1 == a0) merged0[8*k +: 8] = di1[8*k +: 8];
      end
      if (wr0_ok && be0[k]) begin
        merged0[8*k +: 8] = di0[8*k +: 8];
        if (a0 == a1) merged1[8*k +: 8] = di0[8*k +: 8];
      end
    end
  end

  // Memory array: clear writes while busy, otherwise whole merged words.
  always_ff @(posedge clk) begin
    if (busy) begin
      ram[clridx] <= CLRVAL;
    end else begin
      if (wr1_ok) ram[idx1] <= merged1;
      if (wr0_ok) ram[idx0] <= merged0;
    end
  end

  // First read register; data holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      do0_q1  <= '0;
      do1_q1  <= '0;
      vld0_q1 <= 1'b0;
      vld1_q1 <= 1'b0;
    end else begin
      vld0_q1 <= rd0;
      vld1_q1 <= rd1;
      if (rd0) do0_q1 <= rdata0;
      if (rd1) do1_q1 <= rdata1;
    end
  end

  generate
    if (RDLAT == 2) begin : g_lat2
      logic [WIDTH-1:0] do0_q2, do1_q2;
      logic             vld0_q2, vld1_q2;

      // Extra output register for the two-cycle latency option.
      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          do0_q2  <= '0;
          do1_q2  <= '0;
          vld0_q2 <= 1'b0;
          vld1_q2 <= 1'b0;
        end else begin
          vld0_q2 <= vld0_q1;
          vld1_q2 <= vld1_q1;
          if (vld0_q1) do0_q2 <= do0_q1;
          if (vld1_q1) do1_q2 <= do1_q1;
        end
      end

      assign do0  = do0_q2;
      assign do1  = do1_q2;
      assign vld0 = vld0_q2;
      assign vld1 = vld1_q2;
    end else begin : g_lat1
      assign do0  = do0_q1;
      assign do1  = do1_q1;
      assign vld0 = vld0_q1;
      assign vld1 = vld1_q1;
    end
  endgenerate

  // Collision counter and sticky flags; a same-cycle event survives colclr.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      colcnt <= '0;
      colerr <= 1'b0;
      oorerr <= 1'b0;
    end else if (colclr) begin
      colcnt <= col ? CNTBIT'(1) : '0;
      colerr <= col;
      oorerr <= oor;
    end else begin
      if (col && (colcnt != {CNTBIT{1'b1}})) colcnt <= colcnt + CNTBIT'(1);
      colerr <= colerr | col;
      oorerr <= oorerr | oor;
    end
  end

endmodule

// File: tb/tb_iram2rwp.sv
// tb_iram2rwp: drives two RAM instances (WRFIRST/RDLAT=1/CNTBIT=2 and
// RDFIRST/RDLAT=2/CNTBIT=8) with the same stimulus and checks both against
// a word-level memory model plus directed vectors.
module tb_iram2rwp;

  localparam int          DEPTH = 16;
  localparam logic [31:0] CLRV  = 32'hA5A5A5A5;

  typedef struct {
    logic [4:0]  a0;
    logic        we0;
    logic [3:0]  be0;
    logic [31:0] di0;
    logic        re0;
    logic [4:0]  a1;
    logic        we1;
    logic [3:0]  be1;
    logic [31:0] di1;
    logic        re1;
    int          port;
    logic [31:0] exp_wr;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk, rst_, init, colclr;
  logic [4:0]  a0, a1;
  logic        we0, we1, re0, re1;
  logic [3:0]  be0, be1;
  logic [31:0] di0, di1;

  logic        busy_a, vld0_a, vld1_a, colerr_a, oorerr_a;
  logic [31:0] do0_a, do1_a;
  logic [1:0]  colcnt_a;
  logic        busy_b, vld0_b, vld1_b, colerr_b, oorerr_b;
  logic [31:0] do0_b, do1_b;
  logic [7:0]  colcnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [DEPTH];
  bit          busy_m;
  int          clr_ptr;
  logic [31:0] ea_do [2];
  bit          ea_vld [2];
  logic [31:0] eb_do [2];
  bit          eb_vld [2];
  logic [31:0] pend_do [2];
  bit          pend_vld [2];
  int          ea_cnt, eb_cnt;
  bit          e_colerr, e_oorerr;

  vec_t vecs [12];

  iram2rwp #(.ADDRBIT(5), .DEPTH(DEPTH), .WIDTH(32), .RDLAT(1),
             .COLMODE("WRFIRST"), .CLRVAL(CLRV), .CNTBIT(2)) dut_a (
    .clk(clk), .rst_(rst_), .init(init), .busy(busy_a),
    .a0(a0), .we0(we0), .be0(be0), .di0(di0), .re0(re0), .do0(do0_a), .vld0(vld0_a),
    .a1(a1), .we1(we1), .be1(be1), .di1(di1), .re1(re1), .do1(do1_a), .vld1(vld1_a),
    .colclr(colclr), .colerr(colerr_a), .oorerr(oorerr_a), .colcnt(colcnt_a)
  );

  iram2rwp #(.ADDRBIT(5), .DEPTH(DEPTH), .WIDTH(32), .RDLAT(2),
             .COLMODE("RDFIRST"), .CLRVAL(CLRV), .CNTBIT(8)) dut_b (
    .clk(clk), .rst_(rst_), .init(init), .busy(busy_b),
    .a0(a0), .we0(we0), .be0(be0), .di0(di0), .re0(re0), .do0(do0_b), .vld0(vld0_b),
    .a1(a1), .we1(we1), .be1(be1), .di1(di1), .re1(re1), .do1(do1_b), .vld1(vld1_b),
    .colclr(colclr), .colerr(colerr_b), .oorerr(oorerr_b), .colcnt(colcnt_b)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a0 = v.a0; we0 = v.we0; be0 = v.be0; di0 = v.di0; re0 = v.re0;
    a1 = v.a1; we1 = v.we1; be1 = v.be1; di1 = v.di1; re1 = v.re1;
  endtask

  task automatic set_idle();
    a0 = '0; we0 = 1'b0; be0 = '0; di0 = '0; re0 = 1'b0;
    a1 = '0; we1 = 1'b0; be1 = '0; di1 = '0; re1 = 1'b0;
    init = 1'b0; colclr = 1'b0;
  endtask

  task automatic model_reset();
    busy_m = 1'b1;
    clr_ptr = 0;
    for (int p = 0; p < 2; p++) begin
      ea_do[p] = '0; ea_vld[p] = 1'b0;
      eb_do[p] = '0; eb_vld[p] = 1'b0;
      pend_do[p] = '0; pend_vld[p] = 1'b0;
    end
    ea_cnt = 0; eb_cnt = 0;
    e_colerr = 1'b0; e_oorerr = 1'b0;
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic model_edge();
    logic [31:0] oldm [DEPTH];
    int          ad [2];
    logic        wv [2], rv [2];
    logic [3:0]  bv [2];
    logic [31:0] dv [2];
    logic [31:0] rw [2], rr [2];
    bit          acc [2];
    bit          col, oor;
    ad[0] = int'(a0); wv[0] = we0; rv[0] = re0; bv[0] = be0; dv[0] = di0;
    ad[1] = int'(a1); wv[1] = we1; rv[1] = re1; bv[1] = be1; dv[1] = di1;
    col = 1'b0; oor = 1'b0;
    for (int p = 0; p < 2; p++) begin
      acc[p] = 1'b0; rw[p] = '0; rr[p] = '0;
    end
    if (busy_m) begin
      mem[clr_ptr] = CLRV;
      clr_ptr++;
      if (clr_ptr == DEPTH) busy_m = 1'b0;
    end else begin
      oldm = mem;
      for (int p = 1; p >= 0; p--) begin
        if (wv[p] && ad[p] < DEPTH) begin
          for (int k = 0; k < 4; k++)
            if (bv[p][k]) mem[ad[p]][8*k +: 8] = dv[p][8*k +: 8];
        end
      end
      for (int p = 0; p < 2; p++) begin
        acc[p] = rv[p];
        if (ad[p] < DEPTH) begin
          rw[p] = mem[ad[p]];
          rr[p] = oldm[ad[p]];
        end
        if ((wv[p] || rv[p]) && ad[p] >= DEPTH) oor = 1'b1;
      end
      col = (ad[0] == ad[1]) && ((wv[0] && (wv[1] || rv[1])) || (wv[1] && (rv[0] || wv[0])));
      if (init) begin
        busy_m = 1'b1;
        clr_ptr = 0;
      end
    end
    if (colclr) begin
      ea_cnt = col ? 1 : 0;
      eb_cnt = col ? 1 : 0;
      e_colerr = col;
      e_oorerr = oor;
    end else begin
      if (col) begin
        ea_cnt = (ea_cnt < 3) ? ea_cnt + 1 : 3;
        eb_cnt = (eb_cnt < 255) ? eb_cnt + 1 : 255;
      end
      e_colerr = e_colerr | col;
      e_oorerr = e_oorerr | oor;
    end
    for (int p = 0; p < 2; p++) begin
      ea_vld[p] = acc[p];
      if (acc[p]) ea_do[p] = rw[p];
      eb_vld[p] = pend_vld[p];
      if (pend_vld[p]) eb_do[p] = pend_do[p];
      pend_vld[p] = acc[p];
      if (acc[p]) pend_do[p] = rr[p];
    end
  endtask

  task automatic check_all();
    checkOutput("busy_a", 32'(busy_a), 32'(busy_m));
    checkOutput("busy_b", 32'(busy_b), 32'(busy_m));
    checkOutput("vld0_a", 32'(vld0_a), 32'(ea_vld[0]));
    checkOutput("vld1_a", 32'(vld1_a), 32'(ea_vld[1]));
    checkOutput("do0_a", do0_a, ea_do[0]);
    checkOutput("do1_a", do1_a, ea_do[1]);
    checkOutput("vld0_b", 32'(vld0_b), 32'(eb_vld[0]));
    checkOutput("vld1_b", 32'(vld1_b), 32'(eb_vld[1]));
    checkOutput("do0_b", do0_b, eb_do[0]);
    checkOutput("do1_b", do1_b, eb_do[1]);
    checkOutput("colcnt_a", 32'(colcnt_a), 32'(ea_cnt));
    checkOutput("colcnt_b", 32'(colcnt_b), 32'(eb_cnt));
    checkOutput("colerr_a", 32'(colerr_a), 32'(e_colerr));
    checkOutput("colerr_b", 32'(colerr_b), 32'(e_colerr));
    checkOutput("oorerr_a", 32'(oorerr_a), 32'(e_oorerr));
    checkOutput("oorerr_b", 32'(oorerr_b), 32'(e_oorerr));
  endtask

  // One clock: model the edge, let the DUTs take it, sample 1 unit later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Count busy cycles with a bounded loop, optionally poking port 0 writes.
  task automatic count_busy(input string name, input bit poke);
    int cnt = 0;
    while (busy_a && cnt < 40) begin
      if (poke) begin
        a0 = 5'd5; we0 = 1'b1; be0 = 4'hF; di0 = 32'h0000BEEF;
      end
      tick();
      cnt++;
    end
    set_idle();
    checkOutput(name, 32'(cnt), 32'(DEPTH));
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{5'd3, 1'b1, 4'hF, 32'h11223344, 1'b0, 5'd0, 1'b0, 4'h0, 32'h0, 1'b0, -1, 32'h0, 32'h0};
    vecs[1]  = '{5'd3, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, 5'd3, 1'b0, 4'h0, 32'h0, 1'b1, 1, 32'h11BB33DD, 32'h11223344};
    vecs[2]  = '{5'd3, 1'b0, 4'h0, 32'h0, 1'b1, 5'd0, 1'b0, 4'h0, 32'h0, 1'b0, 0, 32'h11BB33DD, 32'h11BB33DD};
    vecs[3]  = '{5'd7, 1'b1, 4'hF, 32'h1, 1'b0, 5'd7, 1'b1, 4'hF, 32'h2, 1'b0, -1, 32'h0, 32'h0};
    vecs[4]  = '{5'd0, 1'b0, 4'h0, 32'h0, 1'b0, 5'd7, 1'b0, 4'h0, 32'h0, 1'b1, 1, 32'h1, 32'h1};
    vecs[5]  = '{5'd9, 1'b1, 4'hC, 32'hFFFF0000, 1'b1, 5'd9, 1'b1, 4'h3, 32'h0000BEEF, 1'b0, 0, 32'hFFFFBEEF, 32'hA5A5A5A5};
    vecs[6]  = '{5'd9, 1'b1, 4'hF, 32'h12345678, 1'b0, 5'd9, 1'b1, 4'h6, 32'hCAFEBABE, 1'b1, 1, 32'h12345678, 32'hFFFFBEEF};
    vecs[7]  = '{5'd20, 1'b0, 4'h0, 32'h0, 1'b1, 5'd0, 1'b0, 4'h0, 32'h0, 1'b0, 0, 32'h0, 32'h0};
    vecs[8]  = '{5'd4, 1'b0, 4'h0, 32'h0, 1'b1, 5'd20, 1'b1, 4'hF, 32'h0BAD0BAD, 1'b0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[9]  = '{5'd0, 1'b0, 4'h0, 32'h0, 1'b0, 5'd4, 1'b0, 4'h0, 32'h0, 1'b1, 1, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[10] = '{5'd3, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 5'd3, 1'b0, 4'h0, 32'h0, 1'b1, 1, 32'h11BB33DD, 32'h11BB33DD};
    vecs[11] = '{5'd9, 1'b0, 4'h0, 32'h0, 1'b1, 5'd0, 1'b0, 4'h0, 32'h0, 1'b0, 0, 32'h12345678, 32'h12345678};

    // Reset and the initial clear.
    rst_ = 1'b0;
    set_idle();
    model_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_ = 1'b1;
    $display("[TB] reset released, waiting for clear");
    count_busy("clear_len", 1'b0);

    // Back-to-back reads of every word on both ports.
    for (int i = 0; i < DEPTH; i++) begin
      a0 = 5'(i); re0 = 1'b1;
      a1 = 5'(DEPTH - 1 - i); re1 = 1'b1;
      tick();
      checkOutput("clr_rd0_a", do0_a, CLRV);
      checkOutput("clr_vld0_a", 32'(vld0_a), 32'd1);
    end
    set_idle();
    tick();
    tick();

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      tick();
      set_idle();
      if (vecs[i].port == 0) checkOutput("tbl_wr0", do0_a, vecs[i].exp_wr);
      if (vecs[i].port == 1) checkOutput("tbl_wr1", do1_a, vecs[i].exp_wr);
      tick();
      if (vecs[i].port == 0) checkOutput("tbl_rd0", do0_b, vecs[i].exp_rd);
      if (vecs[i].port == 1) checkOutput("tbl_rd1", do1_b, vecs[i].exp_rd);
    end
    checkOutput("tbl_cnt_a", 32'(colcnt_a), 32'd3);
    checkOutput("tbl_cnt_b", 32'(colcnt_b), 32'd5);
    checkOutput("tbl_oor", 32'(oorerr_b), 32'd1);

    // colclr alone, then colclr together with a collision, then saturation.
    colclr = 1'b1;
    tick();
    colclr = 1'b0;
    checkOutput("clr_cnt_a", 32'(colcnt_a), 32'd0);
    checkOutput("clr_colerr", 32'(colerr_a), 32'd0);
    checkOutput("clr_oorerr", 32'(oorerr_a), 32'd0);
    colclr = 1'b1; a0 = 5'd2; we0 = 1'b1; be0 = 4'hF; di0 = 32'h22222222; a1 = 5'd2; re1 = 1'b1;
    tick();
    colclr = 1'b0;
    checkOutput("clrcol_cnt", 32'(colcnt_b), 32'd1);
    checkOutput("clrcol_err", 32'(colerr_b), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    set_idle();
    checkOutput("sat_cnt_a", 32'(colcnt_a), 32'd3);
    checkOutput("sat_cnt_b", 32'(colcnt_b), 32'd6);

    // Out-of-range read.
    a0 = 5'd20; re0 = 1'b1;
    tick();
    set_idle();
    checkOutput("oor_do0", do0_a, 32'd0);
    checkOutput("oor_vld0", 32'(vld0_a), 32'd1);
    checkOutput("oor_flag", 32'(oorerr_a), 32'd1);

    // init during traffic; writes during busy must be dropped.
    a0 = 5'd5; we0 = 1'b1; be0 = 4'hF; di0 = 32'h0000DEAD;
    tick();
    set_idle();
    init = 1'b1;
    tick();
    init = 1'b0;
    count_busy("init_len", 1'b1);
    a0 = 5'd5; re0 = 1'b1;
    tick();
    set_idle();
    checkOutput("init_rd_a", do0_a, CLRV);
    tick();
    checkOutput("init_rd_b", do0_b, CLRV);
    checkOutput("init_vld_b", 32'(vld0_b), 32'd1);

    // Reset in the middle of a clear.
    init = 1'b1;
    tick();
    init = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    #2;
    rst_ = 1'b0;
    model_reset();
    #1;
    check_all();
    checkOutput("rst_cnt_b", 32'(colcnt_b), 32'd0);
    checkOutput("rst_busy", 32'(busy_b), 32'd1);
    @(posedge clk);
    #1;
    check_all();
    #3;
    rst_ = 1'b1;
    count_busy("rst_clear_len", 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      v.a0  = 5'($urandom_range(0, 19));
      v.a1  = ($urandom_range(0, 3) == 0) ? v.a0 : 5'($urandom_range(0, 19));
      v.we0 = 1'($urandom_range(0, 1));
      v.we1 = 1'($urandom_range(0, 1));
      v.re0 = 1'($urandom_range(0, 1));
      v.re1 = 1'($urandom_range(0, 1));
      v.be0 = 4'($urandom);
      v.be1 = 4'($urandom);
      v.di0 = $urandom;
      v.di1 = $urandom;
      v.port = -1; v.exp_wr = '0; v.exp_rd = '0;
      applyStimulus(v);
      init   = ($urandom_range(0, 99) == 0);
      colclr = ($urandom_range(0, 19) == 0);
      tick();
    end
    set_idle();
    for (int i = 0; i < 20; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
